// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: widths, memory-stage state encoding,
// byte-enable constants and small access-check helpers.
package pipeline_pkg;

   localparam int DATA_W  = 32;
   localparam int REG_A_W = 5;

   typedef logic [0:0] state_t;

   localparam state_t IDLE = 1'b0;
   localparam state_t BUSY = 1'b1;

   localparam logic [3:0] BE_WORD  = 4'hF;
   localparam logic [3:0] BE_BYTE0 = 4'h1;

   // A word access must sit on a 4-byte boundary; byte accesses never fault.
   function automatic logic is_misaligned(input logic [1:0] lane, input logic is_byte);
      return (!is_byte) && (lane != 2'b00);
   endfunction

endpackage

// File: rtl/mem_lane.sv
// Byte-lane steering for a 32-bit data port: store enables and data
// replication, and load-byte extraction. Purely combinational so it can be
// shared with a data cache.
module mem_lane
   import pipeline_pkg::*;
(
   input  logic [1:0]        lane,
   input  logic              is_byte,
   input  logic [DATA_W-1:0] st_data,
   input  logic [DATA_W-1:0] rdata,
   output logic [3:0]        be,
   output logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] ld_data
);

   logic [7:0] ld_byte_s;

   // Pick the addressed byte out of the read word.
   always_comb begin
      ld_byte_s = rdata[7:0];
      case (lane)
         2'd0:    ld_byte_s = rdata[7:0];
         2'd1:    ld_byte_s = rdata[15:8];
         2'd2:    ld_byte_s = rdata[23:16];
         2'd3:    ld_byte_s = rdata[31:24];
         default: ld_byte_s = rdata[7:0];
      endcase
   end

   // Byte accesses replicate the store byte on every lane and enable one lane;
   // word accesses pass straight through.
   always_comb begin
      be      = BE_WORD;
      wdata   = st_data;
      ld_data = rdata;
      if (is_byte) begin
         be      = BE_BYTE0 << lane;
         wdata   = {4{st_data[7:0]}};
         ld_data = {{(DATA_W-8){1'b0}}, ld_byte_s};
      end else begin
         be      = BE_WORD;
         wdata   = st_data;
         ld_data = rdata;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: ALU results pass through in one cycle, loads/stores run a
// req/ack data-memory transaction while the upstream pipeline is held.
module mem_stage #(
   parameter int DATA_W  = 32,
   parameter int REG_A_W = 5,
   parameter int TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               a_valid,
   input  logic [DATA_W-1:0]  a_pc,
   input  logic [DATA_W-1:0]  a_res,
   input  logic [REG_A_W-1:0] a_r_d_a,
   input  logic               a_w,
   input  logic               a_is_load,
   input  logic               a_is_store,
   input  logic               a_is_byte,
   input  logic [DATA_W-1:0]  a_st_data,
   output logic               m_stall,
   output logic               m_valid,
   output logic [DATA_W-1:0]  m_pc,
   output logic [DATA_W-1:0]  m_res,
   output logic [REG_A_W-1:0] m_r_d_a,
   output logic               m_w,
   output logic               m_exc,
   output logic               dmem_req,
   output logic               dmem_we,
   output logic [DATA_W-1:0]  dmem_addr,
   output logic [DATA_W-1:0]  dmem_wdata,
   output logic [3:0]         dmem_be,
   input  logic [DATA_W-1:0]  dmem_rdata,
   input  logic               dmem_ack
);
   import pipeline_pkg::*;

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_t             state_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [CNT_W-1:0]   cnt_next_s;

   logic               m_valid_r;
   logic [DATA_W-1:0]  m_pc_r;
   logic [DATA_W-1:0]  m_res_r;
   logic [REG_A_W-1:0] m_r_d_a_r;
   logic               m_w_r;
   logic               m_exc_r;
   logic               dmem_req_r;
   logic               dmem_we_r;
   logic [DATA_W-1:0]  dmem_addr_r;
   logic [DATA_W-1:0]  dmem_wdata_r;
   logic [3:0]         dmem_be_r;

   // Bundle captured at accept and replayed to write_back on completion.
   logic [DATA_W-1:0]  lat_pc_r;
   logic [DATA_W-1:0]  lat_addr_r;
   logic [REG_A_W-1:0] lat_r_d_a_r;
   logic               lat_w_r;
   logic               lat_store_r;
   logic               lat_byte_r;

   logic               mem_op_s;
   logic               misalign_s;
   logic [1:0]         lane_s;
   logic               byte_s;
   logic [3:0]         be_s;
   logic [DATA_W-1:0]  wdata_s;
   logic [DATA_W-1:0]  ld_data_s;
   logic [DATA_W-1:0]  done_res_s;

   assign mem_op_s   = a_is_load | a_is_store;
   assign misalign_s = is_misaligned(a_res[1:0], a_is_byte);
   assign cnt_next_s = cnt_r + CNT_W'(1);
   assign done_res_s = lat_store_r ? lat_addr_r : ld_data_s;

   // Lane steering follows the incoming op in IDLE and the latched op in BUSY.
   always_comb begin
      lane_s = a_res[1:0];
      byte_s = a_is_byte;
      if (state_r == BUSY) begin
         lane_s = lat_addr_r[1:0];
         byte_s = lat_byte_r;
      end else begin
         lane_s = a_res[1:0];
         byte_s = a_is_byte;
      end
   end

   mem_lane u_lane (
      .lane    (lane_s),
      .is_byte (byte_s),
      .st_data (a_st_data),
      .rdata   (dmem_rdata),
      .be      (be_s),
      .wdata   (wdata_s),
      .ld_data (ld_data_s)
   );

   // Stage sequencing: pass-through, fault, or memory transaction with timeout.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= IDLE;
         cnt_r        <= '0;
         m_valid_r    <= 1'b0;
         m_pc_r       <= '0;
         m_res_r      <= '0;
         m_r_d_a_r    <= '0;
         m_w_r        <= 1'b0;
         m_exc_r      <= 1'b0;
         dmem_req_r   <= 1'b0;
         dmem_we_r    <= 1'b0;
         dmem_addr_r  <= '0;
         dmem_wdata_r <= '0;
         dmem_be_r    <= 4'h0;
         lat_pc_r     <= '0;
         lat_addr_r   <= '0;
         lat_r_d_a_r  <= '0;
         lat_w_r      <= 1'b0;
         lat_store_r  <= 1'b0;
         lat_byte_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (a_valid) begin
                  if (!mem_op_s) begin
                     m_valid_r <= 1'b1;
                     m_pc_r    <= a_pc;
                     m_res_r   <= a_res;
                     m_r_d_a_r <= a_r_d_a;
                     m_w_r     <= a_w;
                     m_exc_r   <= 1'b0;
                  end else if (misalign_s) begin
                     // Faulting access: reported at once, never reaches memory.
                     m_valid_r <= 1'b1;
                     m_pc_r    <= a_pc;
                     m_res_r   <= a_res;
                     m_r_d_a_r <= a_r_d_a;
                     m_w_r     <= 1'b0;
                     m_exc_r   <= 1'b1;
                  end else begin
                     state_r      <= BUSY;
                     cnt_r        <= '0;
                     m_valid_r    <= 1'b0;
                     dmem_req_r   <= 1'b1;
                     dmem_we_r    <= a_is_store;
                     dmem_addr_r  <= {a_res[DATA_W-1:2], 2'b00};
                     dmem_wdata_r <= wdata_s;
                     dmem_be_r    <= be_s;
                     lat_pc_r     <= a_pc;
                     lat_addr_r   <= a_res;
                     lat_r_d_a_r  <= a_r_d_a;
                     lat_w_r      <= a_w;
                     lat_store_r  <= a_is_store;
                     lat_byte_r   <= a_is_byte;
                  end
               end else begin
                  m_valid_r <= 1'b0;
               end
            end
            BUSY: begin
               if (dmem_ack) begin
                  // Ack beats a simultaneous timeout.
                  state_r    <= IDLE;
                  cnt_r      <= '0;
                  dmem_req_r <= 1'b0;
                  m_valid_r  <= 1'b1;
                  m_pc_r     <= lat_pc_r;
                  m_res_r    <= done_res_s;
                  m_r_d_a_r  <= lat_r_d_a_r;
                  m_w_r      <= lat_w_r;
                  m_exc_r    <= 1'b0;
               end else if (cnt_next_s == CNT_W'(TIMEOUT)) begin
                  state_r    <= IDLE;
                  cnt_r      <= '0;
                  dmem_req_r <= 1'b0;
                  m_valid_r  <= 1'b1;
                  m_pc_r     <= lat_pc_r;
                  m_res_r    <= lat_addr_r;
                  m_r_d_a_r  <= lat_r_d_a_r;
                  m_w_r      <= 1'b0;
                  m_exc_r    <= 1'b1;
               end else begin
                  cnt_r <= cnt_next_s;
               end
            end
            default: begin
               state_r    <= IDLE;
               cnt_r      <= '0;
               dmem_req_r <= 1'b0;
               m_valid_r  <= 1'b0;
            end
         endcase
      end
   end

   assign m_stall    = (state_r == BUSY);
   assign m_valid    = m_valid_r;
   assign m_pc       = m_pc_r;
   assign m_res      = m_res_r;
   assign m_r_d_a    = m_r_d_a_r;
   assign m_w        = m_w_r;
   assign m_exc      = m_exc_r;
   assign dmem_req   = dmem_req_r;
   assign dmem_we    = dmem_we_r;
   assign dmem_addr  = dmem_addr_r;
   assign dmem_wdata = dmem_wdata_r;
   assign dmem_be    = dmem_be_r;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed table, random ops against a
// transaction-level model, and hand-written multi-cycle sequences.
module tb_mem_stage;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        a_valid;
   logic [31:0] a_pc, a_res, a_st_data;
   logic [4:0]  a_r_d_a;
   logic        a_w, a_is_load, a_is_store, a_is_byte;
   logic        m_stall, m_valid, m_w, m_exc;
   logic [31:0] m_pc, m_res;
   logic [4:0]  m_r_d_a;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;

   int n_vec = 0;
   int n_err = 0;

   mem_stage #(.DATA_W(32), .REG_A_W(5), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_pc(a_pc), .a_res(a_res), .a_r_d_a(a_r_d_a),
      .a_w(a_w), .a_is_load(a_is_load), .a_is_store(a_is_store),
      .a_is_byte(a_is_byte), .a_st_data(a_st_data),
      .m_stall(m_stall), .m_valid(m_valid), .m_pc(m_pc), .m_res(m_res),
      .m_r_d_a(m_r_d_a), .m_w(m_w), .m_exc(m_exc),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc, res, sd, rdata;
      logic [4:0]  rd;
      logic        w, ld, st, byt;
      int          ack_k;       // BUSY cycle in which ack is given; 0 = never
      logic [31:0] e_res;
      logic        e_w, e_exc;
      int          e_stall;
      logic        e_req, e_we;
      logic [31:0] e_addr, e_wdata;
      logic [3:0]  e_be;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic [31:0] pc, res, input logic [4:0] rd, input logic w, ld, st, byt,
      input logic [31:0] sd, input int ack_k, input logic [31:0] rdata,
      input logic [31:0] e_res, input logic e_w, e_exc, input int e_stall,
      input logic e_req, input logic [31:0] e_addr, input logic e_we,
      input logic [3:0] e_be, input logic [31:0] e_wdata);
      vec_t v;
      v.pc = pc; v.res = res; v.rd = rd; v.w = w; v.ld = ld; v.st = st; v.byt = byt;
      v.sd = sd; v.ack_k = ack_k; v.rdata = rdata;
      v.e_res = e_res; v.e_w = e_w; v.e_exc = e_exc; v.e_stall = e_stall;
      v.e_req = e_req; v.e_addr = e_addr; v.e_we = e_we; v.e_be = e_be; v.e_wdata = e_wdata;
      return v;
   endfunction

   // Reference model: the outcome of one instruction from the access rules.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      bit   mem = v.ld || v.st;
      int   ln  = int'(v.res[1:0]);
      r.e_req   = mem && !(!v.byt && ln != 0);
      r.e_addr  = v.res - 32'(ln);
      r.e_we    = v.st;
      r.e_be    = v.byt ? 4'(1 << ln) : 4'hF;
      r.e_wdata = v.byt ? (v.sd & 32'hFF) * 32'h01010101 : v.sd;
      if (!mem) begin
         r.e_res = v.res; r.e_w = v.w; r.e_exc = 1'b0; r.e_stall = 0;
      end else if (!r.e_req) begin
         r.e_res = v.res; r.e_w = 1'b0; r.e_exc = 1'b1; r.e_stall = 0;
      end else if (v.ack_k >= 1 && v.ack_k <= TO) begin
         r.e_stall = v.ack_k; r.e_exc = 1'b0; r.e_w = v.w;
         if (v.st)       r.e_res = v.res;
         else if (v.byt) r.e_res = (v.rdata >> (8 * ln)) & 32'hFF;
         else            r.e_res = v.rdata;
      end else begin
         r.e_stall = TO; r.e_exc = 1'b1; r.e_w = 1'b0; r.e_res = v.res;
      end
      return r;
   endfunction

   // Applies one instruction starting just after a falling edge and follows it
   // to its write_back bundle, acting as the data memory.
   task automatic apply(input vec_t v, input string tag);
      int stall_n;
      bit done;
      a_valid = 1'b1; a_pc = v.pc; a_res = v.res; a_r_d_a = v.rd; a_w = v.w;
      a_is_load = v.ld; a_is_store = v.st; a_is_byte = v.byt; a_st_data = v.sd;
      chk({tag, ".stall_pre"}, m_stall, 1'b0);
      @(posedge clk); @(negedge clk);
      a_valid = 1'b0;
      stall_n = 0;
      done = 1'b0;
      if (!v.e_req) begin
         chk({tag, ".req_none"}, dmem_req, 1'b0);
         done = m_valid;
      end else begin
         chk({tag, ".bubble"}, m_valid, 1'b0);
         chk({tag, ".we"}, dmem_we, v.e_we);
         chk({tag, ".be"}, dmem_be, v.e_be);
         chk({tag, ".wdata"}, dmem_wdata, v.e_wdata);
         for (int k = 1; k <= TO + 2 && !done; k++) begin
            if (m_stall) stall_n++;
            chk({tag, ".req_held"}, dmem_req, 1'b1);
            chk({tag, ".addr"}, dmem_addr, v.e_addr);
            dmem_ack   = (k == v.ack_k);
            dmem_rdata = (k == v.ack_k) ? v.rdata : $urandom;
            @(posedge clk); @(negedge clk);
            dmem_ack = 1'b0;
            done = m_valid;
         end
         chk({tag, ".req_drop"}, dmem_req, 1'b0);
      end
      chk({tag, ".done"}, done, 1'b1);
      chk({tag, ".stall_cycles"}, stall_n, v.e_stall);
      chk({tag, ".stall_post"}, m_stall, 1'b0);
      chk({tag, ".pc"}, m_pc, v.pc);
      chk({tag, ".res"}, m_res, v.e_res);
      chk({tag, ".rd"}, m_r_d_a, v.rd);
      chk({tag, ".w"}, m_w, v.e_w);
      chk({tag, ".exc"}, m_exc, v.e_exc);
   endtask

   vec_t tbl[13];
   vec_t rv;

   initial begin
      tbl[0]  = mk(32'h10, 32'd42, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 0, 32'h0,
                   32'd42, 1'b1, 1'b0, 0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      tbl[1]  = mk(32'h14, 32'h100, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 3, 32'hDEADBEEF,
                   32'hDEADBEEF, 1'b1, 1'b0, 3, 1'b1, 32'h100, 1'b0, 4'hF, 32'h0);
      tbl[2]  = mk(32'h18, 32'h203, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hAB, 1, 32'h0,
                   32'h203, 1'b0, 1'b0, 1, 1'b1, 32'h200, 1'b1, 4'h8, 32'hABABABAB);
      tbl[3]  = mk(32'h1C, 32'h201, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 2, 32'h11223344,
                   32'h33, 1'b1, 1'b0, 2, 1'b1, 32'h200, 1'b0, 4'h2, 32'h0);
      tbl[4]  = mk(32'h20, 32'h102, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 0, 32'h0,
                   32'h102, 1'b0, 1'b1, 0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      tbl[5]  = mk(32'h24, 32'h300, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 0, 32'h0,
                   32'h300, 1'b0, 1'b1, 4, 1'b1, 32'h300, 1'b0, 4'hF, 32'h0);
      tbl[6]  = mk(32'h28, 32'h304, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 4, 32'hCAFEF00D,
                   32'hCAFEF00D, 1'b1, 1'b0, 4, 1'b1, 32'h304, 1'b0, 4'hF, 32'h0);
      tbl[7]  = mk(32'h2C, 32'h400, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, 32'h12345678, 1, 32'h0,
                   32'h400, 1'b0, 1'b0, 1, 1'b1, 32'h400, 1'b1, 4'hF, 32'h12345678);
      tbl[8]  = mk(32'h30, 32'h503, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 1, 32'hA1B2C3D4,
                   32'hA1, 1'b1, 1'b0, 1, 1'b1, 32'h500, 1'b0, 4'h8, 32'h0);
      tbl[9]  = mk(32'h34, 32'h500, 5'd11, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 1, 32'hA1B2C3D4,
                   32'hD4, 1'b1, 1'b0, 1, 1'b1, 32'h500, 1'b0, 4'h1, 32'h0);
      tbl[10] = mk(32'h38, 32'h101, 5'd12, 1'b0, 1'b0, 1'b1, 1'b0, 32'h55AA55AA, 0, 32'h0,
                   32'h101, 1'b0, 1'b1, 0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      tbl[11] = mk(32'h3C, 32'h601, 5'd13, 1'b1, 1'b0, 1'b1, 1'b1, 32'h123456EF, 2, 32'h0,
                   32'h601, 1'b1, 1'b0, 2, 1'b1, 32'h600, 1'b1, 4'h2, 32'hEFEFEFEF);
      tbl[12] = mk(32'h40, 32'hFFFF0001, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 32'h0,
                   32'hFFFF0001, 1'b0, 1'b0, 0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);

      reset = 1'b1; a_valid = 1'b0; a_pc = '0; a_res = '0; a_r_d_a = '0; a_w = 1'b0;
      a_is_load = 1'b0; a_is_store = 1'b0; a_is_byte = 1'b0; a_st_data = '0;
      dmem_ack = 1'b0; dmem_rdata = '0;
      repeat (2) @(negedge clk);
      chk("rst.m_valid", m_valid, 1'b0);
      chk("rst.m_stall", m_stall, 1'b0);
      chk("rst.dmem_req", dmem_req, 1'b0);
      chk("rst.m_res", m_res, 32'h0);
      chk("rst.m_exc", m_exc, 1'b0);
      chk("rst.dmem_be", dmem_be, 4'h0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 13; i++) apply(tbl[i], $sformatf("tbl%0d", i));

      // Back-to-back: misaligned fault, then two ALU ops, one per cycle.
      a_valid = 1'b1; a_pc = 32'h80; a_res = 32'h102; a_r_d_a = 5'd1; a_w = 1'b1;
      a_is_load = 1'b1; a_is_store = 1'b0; a_is_byte = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("b2b.exc0", m_exc, 1'b1);
      chk("b2b.w0", m_w, 1'b0);
      chk("b2b.stall0", m_stall, 1'b0);
      a_pc = 32'h84; a_res = 32'h777; a_r_d_a = 5'd2; a_is_load = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("b2b.valid1", m_valid, 1'b1);
      chk("b2b.res1", m_res, 32'h777);
      chk("b2b.exc1", m_exc, 1'b0);
      a_pc = 32'h88; a_res = 32'h888; a_r_d_a = 5'd3; a_w = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("b2b.res2", m_res, 32'h888);
      chk("b2b.pc2", m_pc, 32'h88);
      chk("b2b.w2", m_w, 1'b0);
      a_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("idle.valid", m_valid, 1'b0);
      chk("idle.pc_hold", m_pc, 32'h88);
      chk("idle.res_hold", m_res, 32'h888);

      // Random ops against the reference model.
      for (int i = 0; i < 60; i++) begin
         int kind = int'($urandom_range(0, 3));
         rv.pc = $urandom; rv.res = $urandom; rv.sd = $urandom; rv.rdata = $urandom;
         rv.rd = 5'($urandom); rv.w = 1'($urandom); rv.byt = 1'($urandom);
         rv.ld = (kind == 1) || (kind == 3);
         rv.st = (kind == 2) || (kind == 3 && $urandom_range(0, 3) == 0);
         if ($urandom_range(0, 3) != 0 && !rv.byt) rv.res[1:0] = 2'b00;
         rv.ack_k = int'($urandom_range(1, TO + 2));
         apply(model(rv), $sformatf("rnd%0d", i));
      end

      // Reset in the second BUSY cycle: everything drops, nothing completes.
      a_valid = 1'b1; a_pc = 32'h90; a_res = 32'h700; a_r_d_a = 5'd4; a_w = 1'b1;
      a_is_load = 1'b1; a_is_store = 1'b0; a_is_byte = 1'b0;
      @(posedge clk); @(negedge clk);
      a_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("rbusy.stall_pre", m_stall, 1'b1);
      reset = 1'b1;
      #1;
      chk("rbusy.req", dmem_req, 1'b0);
      chk("rbusy.stall", m_stall, 1'b0);
      chk("rbusy.valid", m_valid, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
         @(posedge clk); @(negedge clk);
         chk("rbusy.no_done", m_valid, 1'b0);
         chk("rbusy.no_req", dmem_req, 1'b0);
      end
      dmem_ack = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
